// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare peripheral on the EX-stage data bus.
// Prescaled up-counter with compare match, auto-reload or one-shot, and a level IRQ.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned PRE_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        hit,
  output logic        irq
);

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_COUNT  = 3'd1;
  localparam logic [2:0] IDX_CMP    = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;
  localparam logic [2:0] IDX_PRE    = 3'd4;

  // CTRL bit positions: [0] EN, [1] AUTO, [2] IRQ_EN
  logic [2:0]       ctrl_reg, ctrl_next;
  logic [31:0]      count_reg, count_next;
  logic [31:0]      cmp_reg, cmp_next;
  logic             match_reg, match_next;
  logic [PRE_W-1:0] prescale_reg, prescale_next;
  logic [PRE_W-1:0] pre_cnt_reg, pre_cnt_next;

  logic             sel;
  logic [2:0]       idx;
  logic [4:0]       wr_sel;
  logic [7:0][31:0] rd_word;
  logic             tick;
  logic             tick_eval;
  logic             match_evt;
  logic             unused_byte_lanes;

  assign sel = en & (addr[31:5] == BASE_ADDR[31:5]);
  assign hit = sel;
  assign idx = addr[4:2];
  assign unused_byte_lanes = ^addr[1:0];

  for (genvar gi = 0; gi < 5; gi++) begin : g_wr_sel
    assign wr_sel[gi] = sel & rw & (idx == 3'(gi));
  end

  assign rd_word[IDX_CTRL]   = {29'd0, ctrl_reg};
  assign rd_word[IDX_COUNT]  = count_reg;
  assign rd_word[IDX_CMP]    = cmp_reg;
  assign rd_word[IDX_STATUS] = {31'd0, match_reg};
  assign rd_word[IDX_PRE]    = 32'(prescale_reg);
  for (genvar gi = 5; gi < 8; gi++) begin : g_rsvd
    assign rd_word[gi] = '0;
  end

  assign d_out = (sel & ~rw) ? rd_word[idx] : '0;
  assign irq   = match_reg & ctrl_reg[2];

  // A COUNT write in a tick cycle replaces the tick's effect entirely,
  // including the compare, so the match is gated here rather than later.
  assign tick      = ctrl_reg[0] & (pre_cnt_reg == prescale_reg);
  assign tick_eval = tick & ~wr_sel[IDX_COUNT];
  assign match_evt = tick_eval & (count_reg == cmp_reg);

  always_comb begin
    ctrl_next     = ctrl_reg;
    count_next    = count_reg;
    cmp_next      = cmp_reg;
    match_next    = match_reg;
    prescale_next = prescale_reg;
    pre_cnt_next  = pre_cnt_reg;

    if (!ctrl_reg[0] || tick) begin
      pre_cnt_next = '0;
    end else begin
      pre_cnt_next = pre_cnt_reg + PRE_W'(1);
    end

    if (tick_eval) begin
      if (match_evt) begin
        match_next = 1'b1;
        if (ctrl_reg[1]) begin
          count_next = '0;
        end else begin
          ctrl_next[0] = 1'b0;
        end
      end else begin
        count_next = count_reg + 32'd1;
      end
    end

    // Bus writes come last so they override the tick's updates.
    if (wr_sel[IDX_STATUS] && d_in[0] && !match_evt) begin
      match_next = 1'b0;
    end
    if (wr_sel[IDX_CTRL]) begin
      ctrl_next    = d_in[2:0];
      pre_cnt_next = '0;
    end
    if (wr_sel[IDX_COUNT]) begin
      count_next = d_in;
    end
    if (wr_sel[IDX_CMP]) begin
      cmp_next = d_in;
    end
    if (wr_sel[IDX_PRE]) begin
      prescale_next = d_in[PRE_W-1:0];
      pre_cnt_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg     <= '0;
      count_reg    <= '0;
      cmp_reg      <= '0;
      match_reg    <= 1'b0;
      prescale_reg <= '0;
      pre_cnt_reg  <= '0;
    end else begin
      ctrl_reg     <= ctrl_next;
      count_reg    <= count_next;
      cmp_reg      <= cmp_next;
      match_reg    <= match_next;
      prescale_reg <= prescale_next;
      pre_cnt_reg  <= pre_cnt_next;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus randomized bus traffic,
// all compared every cycle against a behavioural model of the register map.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        hit;
  logic        irq;

  mmio_timer #(.BASE_ADDR(BASE), .PRE_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .rw(rw), .addr(addr),
    .d_in(d_in), .d_out(d_out), .hit(hit), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en_b;
    logic        auto_b;
    logic        irqen_b;
    logic [31:0] count;
    logic [31:0] cmp;
    logic        match;
    logic [15:0] prescale;
    logic [15:0] phase;   // cycles spent in the current prescaler period
  } mstate_t;

  mstate_t     m;
  int          n_checks;
  int          n_fail;
  logic [31:0] last_dout;
  logic        last_hit;
  logic        last_irq;

  function automatic logic in_win(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] reg_val(input mstate_t s, input logic [2:0] k);
    case (k)
      3'd0:    return {29'd0, s.irqen_b, s.auto_b, s.en_b};
      3'd1:    return s.count;
      3'd2:    return s.cmp;
      3'd3:    return {31'd0, s.match};
      3'd4:    return {16'd0, s.prescale};
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the timer as described by its register-level rules.
  function automatic mstate_t model_next(input mstate_t s, input logic r, input logic e,
                                         input logic w, input logic [31:0] a,
                                         input logic [31:0] d);
    mstate_t     n;
    logic        wr;
    logic [2:0]  k;
    logic        tick;
    logic        evt;
    n    = s;
    if (r) return '0;
    wr   = e && w && in_win(a);
    k    = a[4:2];
    tick = s.en_b && (s.phase == s.prescale);
    evt  = 1'b0;
    n.phase = (s.en_b && !tick) ? s.phase + 16'd1 : 16'd0;
    if (tick && !(wr && k == 3'd1)) begin
      if (s.count == s.cmp) begin
        evt     = 1'b1;
        n.match = 1'b1;
        if (s.auto_b) n.count = 32'd0;
        else          n.en_b  = 1'b0;
      end else begin
        n.count = s.count + 32'd1;
      end
    end
    if (wr) begin
      case (k)
        3'd0: begin n.en_b = d[0]; n.auto_b = d[1]; n.irqen_b = d[2]; n.phase = 16'd0; end
        3'd1: n.count = d;
        3'd2: n.cmp = d;
        3'd3: if (d[0] && !evt) n.match = 1'b0;
        3'd4: begin n.prescale = d[15:0]; n.phase = 16'd0; end
        default: ;
      endcase
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one bus cycle, compare all outputs with the model mid-cycle, advance the model.
  task automatic step(input logic e, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        exp_hit;
    logic [31:0] exp_dout;
    logic        exp_irq;
    en = e; rw = w; addr = a; d_in = d;
    @(negedge clk);
    exp_hit  = e && in_win(a);
    exp_dout = (exp_hit && !w) ? reg_val(m, a[4:2]) : 32'd0;
    exp_irq  = m.match && m.irqen_b;
    chk("hit", 32'(hit), 32'(exp_hit));
    chk("d_out", d_out, exp_dout);
    chk("irq", 32'(irq), 32'(exp_irq));
    last_dout = d_out;
    last_hit  = hit;
    last_irq  = irq;
    @(posedge clk);
    m = model_next(m, rst, e, w, a, d);
    #1;
  endtask

  task automatic wr(input int k, input logic [31:0] d);
    step(1'b1, 1'b1, BASE + 32'(k * 4), d);
  endtask

  task automatic rd_expect(input int k, input logic [31:0] exp, input string name);
    step(1'b1, 1'b0, BASE + 32'(k * 4), $urandom);
    chk(name, last_dout, exp);
  endtask

  task automatic irq_expect(input logic exp, input string name);
    chk(name, 32'(last_irq), 32'(exp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 31)), $urandom);
    end
  endtask

  logic [31:0] wrap_seq [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; en = 1'b0; rw = 1'b0; addr = '0; d_in = '0;
    m = '0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, BASE, 32'd0);
    rst = 1'b0;

    // Reset in the middle of a count
    wr(2, 32'd100); wr(4, 32'd0); wr(0, 32'd1);
    rd_expect(1, 32'd0, "rst_count_start");
    idle(6);
    rst = 1'b1;
    rd_expect(1, 32'd7, "count_before_rst");
    rst = 1'b0;
    rd_expect(0, 32'd0, "ctrl_after_rst");
    rd_expect(1, 32'd0, "count_after_rst");
    rd_expect(2, 32'd0, "cmp_after_rst");
    irq_expect(1'b0, "irq_after_rst");
    idle(1);
    chk("hit_idle", 32'(last_hit), 32'd0);

    // Periodic, no prescale: match 4 cycles after the CTRL write
    wr(2, 32'd3); wr(4, 32'd0); wr(0, 32'd7);
    for (int i = 0; i < 4; i++) begin
      rd_expect(1, 32'(i), "per_count");
      irq_expect(1'b0, "per_irq_low");
    end
    rd_expect(3, 32'd1, "per_match");
    irq_expect(1'b1, "per_irq_high");
    wr(3, 32'd1);
    rd_expect(1, 32'd2, "per_count_after_clr");
    irq_expect(1'b0, "per_irq_cleared");
    rd_expect(1, 32'd3, "per_count3");
    rd_expect(3, 32'd1, "per_match2");
    irq_expect(1'b1, "per_irq_again");
    wr(0, 32'd0); wr(3, 32'd1); wr(1, 32'd0);

    // Prescaled one-shot: match 6 cycles after enable
    wr(4, 32'd2); wr(2, 32'd1); wr(0, 32'd1);
    for (int i = 0; i < 6; i++) rd_expect(3, 32'd0, "os_wait");
    rd_expect(3, 32'd1, "os_match");
    irq_expect(1'b0, "os_irq_masked");
    rd_expect(0, 32'd0, "os_ctrl_off");
    rd_expect(1, 32'd1, "os_count_hold");
    idle(4);
    rd_expect(1, 32'd1, "os_count_still");

    // Wrap through 0xFFFF_FFFF without a flag
    wrap_seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    wr(3, 32'd1); wr(4, 32'd0); wr(2, 32'd5); wr(1, 32'hFFFF_FFFE); wr(0, 32'd5);
    for (int i = 0; i < 8; i++) begin
      rd_expect(1, wrap_seq[i], "wrap_count");
      irq_expect(1'b0, "wrap_no_irq");
    end
    rd_expect(3, 32'd1, "wrap_match");
    irq_expect(1'b1, "wrap_irq");
    rd_expect(0, 32'd4, "wrap_ctrl_oneshot");
    rd_expect(1, 32'd5, "wrap_count_hold");

    // STATUS clear in the same cycle as a match: set wins
    wr(0, 32'd0); wr(3, 32'd1); wr(1, 32'd0); wr(4, 32'd0); wr(2, 32'd2); wr(0, 32'd3);
    idle(5);
    wr(3, 32'd1);
    rd_expect(3, 32'd1, "clr_vs_match");
    wr(3, 32'd1);
    rd_expect(3, 32'd0, "clr_alone");

    // COUNT write coinciding with a tick
    wr(2, 32'h100);
    wr(1, 32'h10);
    rd_expect(1, 32'h10, "cnt_wr_wins");
    rd_expect(1, 32'h11, "cnt_wr_then_inc");

    // COUNT write suppresses a match that would otherwise fire
    wr(0, 32'd0); wr(3, 32'd1); wr(2, 32'd5); wr(1, 32'd5); wr(0, 32'd3);
    wr(1, 32'h20);
    rd_expect(3, 32'd0, "cnt_wr_blocks_match");
    rd_expect(1, 32'h21, "cnt_wr_blocks_inc");

    // Decode window and reserved slots
    wr(0, 32'd0);
    wr(2, 32'hA5A5_0003);
    step(1'b1, 1'b0, BASE + 32'h20, 32'd0);
    chk("dec_above_hit", 32'(last_hit), 32'd0);
    chk("dec_above_dout", last_dout, 32'd0);
    step(1'b1, 1'b0, BASE - 32'd4, 32'd0);
    chk("dec_below_hit", 32'(last_hit), 32'd0);
    chk("dec_below_dout", last_dout, 32'd0);
    step(1'b1, 1'b0, BASE + 32'h14, 32'd0);
    chk("dec_rsvd_hit", 32'(last_hit), 32'd1);
    chk("dec_rsvd_dout", last_dout, 32'd0);
    step(1'b1, 1'b1, BASE + 32'h20, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, BASE - 32'd4, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, BASE + 32'h14, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, BASE + 32'h1C, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, BASE + 32'h0A, 32'd0);
    chk("dec_byte_cmp", last_dout, 32'hA5A5_0003);
    rd_expect(0, 32'd0, "dec_ctrl_untouched");
    rd_expect(2, 32'hA5A5_0003, "dec_cmp_untouched");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int          k;
      logic        e;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      rst = ($urandom_range(0, 199) == 0);
      e   = ($urandom_range(0, 9) < 7);
      w   = 1'($urandom_range(0, 1));
      k   = $urandom_range(0, 7);
      a   = BASE + 32'(k * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      case (k)
        0:       d = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
        1, 2:    d = 32'($urandom_range(0, 12));
        4:       d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      step(e, w, a, d);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
